// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// -------------------
// MEM-stage memory controller. It takes the EXE/MEM register outputs and
// performs each 32-bit load or store as two 16-bit SRAM accesses, low half
// first. Each half is held for WAIT_CYCLES+1 cycles. While the access is in
// flight the controller raises `stall`, which freezes the PC and the
// IF/ID, ID/EXE and EXE/MEM registers.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   MEM_R_en     : load request
//   MEM_W_en     : store request (wins when both enables are set)
//   ALU_result   : byte address (bits [1:0] ignored, upper bits wrap)
//   ST_value     : store data
//   read_data    : last completed load word, held until the next load
//   stall        : pipeline freeze request
//   SRAM_ADDR    : halfword address
//   SRAM_DQ_out  : write data toward the DQ tri-state buffer
//   SRAM_DQ_in   : read data from the DQ pins
//   SRAM_DQ_oe   : DQ tri-state drive enable
//   SRAM_WE_N    : write strobe, active low
//   SRAM_OE_N    : output enable, active low
module mem_stage_sram_ctrl #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_en,
  input  logic               MEM_W_en,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_value,
  output logic [31:0]        read_data,
  output logic               stall,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  input  logic [15:0]        SRAM_DQ_in,
  output logic               SRAM_DQ_oe,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t             state;
  logic [3:0]         cnt;
  logic               is_wr;
  logic [SRAM_AW-2:0] word_addr;
  logic [31:0]        data;
  logic [15:0]        low_half;
  logic               req;
  logic               unused_addr_bits;

  assign req = MEM_R_en | MEM_W_en;

  // Byte-offset bits and the bits above the SRAM range are deliberately dropped.
  assign unused_addr_bits = ^{ALU_result[31:SRAM_AW+1], ALU_result[1:0]};

  // Access sequencer. Operands are latched when leaving IDLE, so the
  // pipeline inputs may change freely while the access is in flight.
  // The load word is assembled on the HIGH->DONE edge so it is already
  // valid during the single DONE cycle that releases the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      word_addr <= '0;
      data      <= '0;
      low_half  <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_wr     <= MEM_W_en;
            word_addr <= ALU_result[SRAM_AW:2];
            data      <= ST_value;
            cnt       <= '0;
            state     <= LOW;
          end
        end
        LOW: begin
          if (cnt == WAIT_LAST) begin
            if (!is_wr) low_half <= SRAM_DQ_in;
            cnt   <= '0;
            state <= HIGH;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt == WAIT_LAST) begin
            if (!is_wr) read_data <= {SRAM_DQ_in, low_half};
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM strobes decode from the current state. Reset forces everything
  // inactive immediately so a held reset never glitches a write.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    if (!rst) begin
      case (state)
        LOW, HIGH: begin
          SRAM_ADDR = {word_addr, (state == HIGH)};
          if (is_wr) begin
            SRAM_DQ_out = (state == HIGH) ? data[31:16] : data[15:0];
            SRAM_DQ_oe  = 1'b1;
            SRAM_WE_N   = 1'b0;
          end else begin
            SRAM_OE_N = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The request cycle itself stalls; DONE releases the pipeline for one cycle.
  assign stall = !rst && req && (state != DONE);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl
// ----------------------
// Directed self-checking bench for mem_stage_sram_ctrl. One instance uses
// the default WAIT_CYCLES=2 and talks to a small SRAM model; a second
// instance with WAIT_CYCLES=0 checks the short-latency timing.
module tb_mem_stage_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_value;
  logic [31:0] read_data;
  logic        stall;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        mem_r_en_w0, mem_w_en_w0;
  logic [31:0] alu_result_w0, st_value_w0;
  logic [31:0] read_data_w0;
  logic        stall_w0;
  logic [17:0] sram_addr_w0;
  logic [15:0] sram_dq_out_w0;
  logic        sram_dq_oe_w0, sram_we_n_w0, sram_oe_n_w0;

  logic [15:0] sram_mem [0:255];

  int checks = 0;
  int errors = 0;

  mem_stage_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_en(mem_r_en), .MEM_W_en(mem_w_en),
    .ALU_result(alu_result), .ST_value(st_value),
    .read_data(read_data), .stall(stall),
    .SRAM_ADDR(sram_addr), .SRAM_DQ_out(sram_dq_out), .SRAM_DQ_in(sram_dq_in),
    .SRAM_DQ_oe(sram_dq_oe), .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n)
  );

  mem_stage_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .MEM_R_en(mem_r_en_w0), .MEM_W_en(mem_w_en_w0),
    .ALU_result(alu_result_w0), .ST_value(st_value_w0),
    .read_data(read_data_w0), .stall(stall_w0),
    .SRAM_ADDR(sram_addr_w0), .SRAM_DQ_out(sram_dq_out_w0), .SRAM_DQ_in(16'h0000),
    .SRAM_DQ_oe(sram_dq_oe_w0), .SRAM_WE_N(sram_we_n_w0), .SRAM_OE_N(sram_oe_n_w0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple asynchronous-read SRAM; writes land on the rising edge.
  assign sram_dq_in = (!sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w,
                               input logic [31:0] addr, input logic [31:0] value);
    mem_r_en   = r;
    mem_w_en   = w;
    alu_result = addr;
    st_value   = value;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Checks one cycle of a WAIT_CYCLES=2 access that started in cycle 0:
  // low half in cycles 1..3, high half in cycles 4..6, DONE in cycle 7.
  task automatic checkAccessCycle(input int c, input logic wr, input logic [17:0] lo_addr,
                                  input logic [15:0] d_lo, input logic [15:0] d_hi);
    logic        in_lo, in_hi;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    in_lo    = (c >= 1 && c <= 3);
    in_hi    = (c >= 4 && c <= 6);
    exp_addr = in_lo ? lo_addr : (in_hi ? (lo_addr | 18'd1) : 18'd0);
    exp_dq   = (wr && in_lo) ? d_lo : ((wr && in_hi) ? d_hi : 16'h0000);
    checkOutput($sformatf("stall c%0d", c), {31'd0, stall}, {31'd0, (c <= 6)});
    checkOutput($sformatf("addr c%0d", c), {14'd0, sram_addr}, {14'd0, exp_addr});
    checkOutput($sformatf("we_n c%0d", c), {31'd0, sram_we_n}, {31'd0, !(wr && (in_lo || in_hi))});
    checkOutput($sformatf("oe_n c%0d", c), {31'd0, sram_oe_n}, {31'd0, !(!wr && (in_lo || in_hi))});
    checkOutput($sformatf("dq_oe c%0d", c), {31'd0, sram_dq_oe}, {31'd0, (wr && (in_lo || in_hi))});
    if (wr) checkOutput($sformatf("dq_out c%0d", c), {16'd0, sram_dq_out}, {16'd0, exp_dq});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
    rst = 1'b1;
    mem_r_en_w0 = 1'b0; mem_w_en_w0 = 1'b0; alu_result_w0 = '0; st_value_w0 = '0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222);

    // Reset held two cycles with a store request pending.
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("rst we_n", {31'd0, sram_we_n}, 32'd1);
      checkOutput("rst stall", {31'd0, stall}, 32'd0);
      checkOutput("rst read_data", read_data, 32'h0);
      checkOutput("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Store 0xDEADBEEF to byte address 0x10 -> halfwords 0x8/0x9.
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      checkAccessCycle(c, 1'b1, 18'h8, 16'hBEEF, 16'hDEAD);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("store mem lo", {16'd0, sram_mem[8]}, 32'h0000_BEEF);
    checkOutput("store mem hi", {16'd0, sram_mem[9]}, 32'h0000_DEAD);

    // Load from 0x10 with the model preloaded; then a store follows right
    // after DONE, and read_data must survive the store.
    sram_mem[8] = 16'hBEEF;
    sram_mem[9] = 16'hDEAD;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      checkAccessCycle(c, 1'b0, 18'h8, 16'h0, 16'h0);
    end
    checkOutput("load read_data", read_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    for (int c = 0; c <= 7; c++) begin
      tick();
      checkAccessCycle(c, 1'b1, 18'h10, 16'h5678, 16'h1234);
      checkOutput($sformatf("b2b read_data c%0d", c), read_data, 32'hDEAD_BEEF);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("b2b mem lo", {16'd0, sram_mem[8'h10]}, 32'h0000_5678);
    checkOutput("b2b mem hi", {16'd0, sram_mem[8'h11]}, 32'h0000_1234);

    // Both enables: write wins, read_data unchanged.
    applyStimulus(1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      checkAccessCycle(c, 1'b1, 18'h18, 16'hF00D, 16'hCAFE);
    end
    checkOutput("both read_data", read_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("both mem hi", {16'd0, sram_mem[8'h19]}, 32'h0000_CAFE);

    // Both enables on the WAIT_CYCLES=0 instance: stall for cycles 0..2, DONE in 3.
    mem_r_en_w0 = 1'b1; mem_w_en_w0 = 1'b1;
    alu_result_w0 = 32'h0000_0030; st_value_w0 = 32'hCAFE_F00D;
    #1;
    checkOutput("w0 stall c0", {31'd0, stall_w0}, 32'd1);
    tick();
    checkOutput("w0 stall c1", {31'd0, stall_w0}, 32'd1);
    checkOutput("w0 we_n c1", {31'd0, sram_we_n_w0}, 32'd0);
    checkOutput("w0 addr c1", {14'd0, sram_addr_w0}, 32'h18);
    checkOutput("w0 dq_out c1", {16'd0, sram_dq_out_w0}, 32'hF00D);
    tick();
    checkOutput("w0 stall c2", {31'd0, stall_w0}, 32'd1);
    checkOutput("w0 addr c2", {14'd0, sram_addr_w0}, 32'h19);
    checkOutput("w0 dq_out c2", {16'd0, sram_dq_out_w0}, 32'hCAFE);
    tick();
    checkOutput("w0 stall c3", {31'd0, stall_w0}, 32'd0);
    checkOutput("w0 we_n c3", {31'd0, sram_we_n_w0}, 32'd1);
    checkOutput("w0 oe_n c3", {31'd0, sram_oe_n_w0}, 32'd1);
    checkOutput("w0 read_data", read_data_w0, 32'h0);
    mem_r_en_w0 = 1'b0; mem_w_en_w0 = 1'b0;
    tick();

    // Reset asserted in cycle 4 of a load abandons it.
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) tick();
      checkAccessCycle(c, 1'b0, 18'h8, 16'h0, 16'h0);
    end
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("midrst stall", {31'd0, stall}, 32'd0);
    checkOutput("midrst oe_n", {31'd0, sram_oe_n}, 32'd1);
    checkOutput("midrst addr", {14'd0, sram_addr}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("postrst stall", {31'd0, stall}, 32'd0);
    checkOutput("postrst oe_n", {31'd0, sram_oe_n}, 32'd1);
    checkOutput("postrst we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("postrst read_data", read_data, 32'h0);
    tick();

    // Fresh load after the abandoned one.
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      checkAccessCycle(c, 1'b0, 18'h8, 16'h0, 16'h0);
    end
    checkOutput("reload read_data", read_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("idle read_data hold", read_data, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM-stage memory controller. It consumes the EXE/MEM pipeline register outputs (ALU_result as byte address, ST_value as store data, MEM_R_en/MEM_W_en as access type) and performs each 32-bit access as two 16-bit SRAM accesses with programmable wait states.
- Asserts `stall` to freeze the PC, IF/ID, ID/EXE and EXE/MEM registers until the access completes.
- Delivers the 32-bit load word toward the MEM/WB register.
- dest/WB_en pass-through stays in the MEM stage top and is out of scope.

Parameters:
- SRAM_AW, 18, SRAM halfword address width.
- WAIT_CYCLES, 2, extra cycles each half-access is held; each half lasts WAIT_CYCLES+1 cycles. Legal range 0..15.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- MEM_R_en  in  1  load request from EXE/MEM register
- MEM_W_en  in  1  store request from EXE/MEM register
- ALU_result  in  32  byte address
- ST_value  in  32  store data
- read_data  out  32  assembled load word
- stall  out  1  freeze request to pipeline registers and PC
- SRAM_ADDR  out  SRAM_AW  halfword address
- SRAM_DQ_out  out  16  write data to SRAM
- SRAM_DQ_in  in  16  read data from SRAM
- SRAM_DQ_oe  out  1  drive enable for DQ tri-state at top level
- SRAM_WE_N  out  1  write strobe, active low
- SRAM_OE_N  out  1  output enable, active low

Behaviour:
- Reset values and clock:
  - One clock; reset is synchronous and active-high.
  - On rst: state=IDLE, cnt=0, read_data=0, latched addr/data/type=0.
  - While rst=1, outputs are combinationally forced: stall=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_out=0.
- States: IDLE, LOW, HIGH, DONE.
- req = MEM_R_en | MEM_W_en. Write has priority: if both are 1, the access is a write and read_data is unchanged.
- IDLE:
  - If req, latch is_wr, ALU_result[SRAM_AW:2] and ST_value; cnt<=0; go to LOW.
- LOW:
  - SRAM_ADDR = {word_addr, 1'b0}.
  - Write: DQ_out = data[15:0], DQ_oe=1, WE_N=0.
  - Read: OE_N=0.
  - When cnt==WAIT_CYCLES: a read captures SRAM_DQ_in into low_half; cnt<=0; go to HIGH. Otherwise cnt<=cnt+1.
- HIGH:
  - Same as LOW, with SRAM_ADDR = {word_addr, 1'b1} and data[31:16].
  - When cnt==WAIT_CYCLES: a read captures the high half; go to DONE.
- DONE:
  - For a read, read_data <= {high_half, low_half} at entry, so it is valid during DONE.
  - Strobes inactive; go to IDLE unconditionally.
- In IDLE and DONE: WE_N=1, OE_N=1, DQ_oe=0, ADDR=0, DQ_out=0.
- stall = req & (state != DONE), combinational.
  - The request cycle itself already stalls.
  - DONE releases the pipeline for exactly one cycle.
  - The next instruction's request is seen in IDLE on the following cycle; there are no back-to-back accesses without an IDLE cycle.
- Latency: a request in cycle 0 gives stall=1 for cycles 0..2*(WAIT_CYCLES+1), and DONE in cycle 2*(WAIT_CYCLES+1)+1.
  - WAIT_CYCLES=2: stall high for cycles 0..6; DONE in cycle 7.
- Inputs change while busy: has no effect, because operands are latched at IDLE→LOW. A request deasserting mid-access still completes the SRAM access.
- Reset mid-operation: the access is abandoned and state is IDLE after the edge. A partial SRAM write may have occurred; read_data keeps its reset value 0.
- read_data holds its value until the next completed read. Writes never modify it.
- ALU_result[1:0] is ignored (word-aligned access only). Upper address bits above SRAM_AW+1 are ignored, so addresses wrap.

Test Plan:
- Reset check: rst=1 for 2 cycles with MEM_W_en=1 → WE_N=1, stall=0, read_data=0 during reset.
- Store: MEM_W_en=1, ALU_result=0x0000_0010, ST_value=0xDEAD_BEEF, WAIT=2 →
  - ADDR=0x8 with DQ_out=0xBEEF, WE_N=0 for cycles 1..3.
  - ADDR=0x9 with 0xDEAD for cycles 4..6.
  - stall=1 for cycles 0..6 and 0 in cycle 7.
- Load: SRAM model preloaded with 0x8=0xBEEF and 0x9=0xDEAD; MEM_R_en=1, ALU_result=0x10 → read_data=0xDEADBEEF in DONE cycle 7. OE_N=0 and DQ_oe=0 throughout.
- Back-to-back: load then store held on the inputs → second access starts in the cycle after DONE (IDLE), and read_data keeps 0xDEADBEEF through the store.
- Both enables: MEM_R_en=MEM_W_en=1 → write is performed and read_data is unchanged. Repeat with WAIT_CYCLES=0 → stall high exactly 3 cycles, DONE at cycle 3.
- Reset mid-operation: rst in cycle 4 of a load → state IDLE, strobes inactive, stall=0 after the edge, read_data=0. A fresh load then completes correctly.
